// File: rtl/mac_accumulator.sv
// Accumulates a programmed number of 16-bit products into an ACC_W-bit sum and
// presents the result through a valid/ready handshake. Optional build macro:
// MAC_ACCUMULATOR_SATURATE_EN (clamp on carry-out instead of wrapping).
module mac_accumulator #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic             cclk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic [15:0]      prod_in,
    input  logic             prod_valid,
    output logic [ACC_W-1:0] acc_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overflow
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t           state_reg, state_next;
    logic [ACC_W-1:0] acc_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] len_reg;
    logic             ovf_reg;

    logic [ACC_W:0]   sum;
    logic             carry;
    logic [ACC_W-1:0] acc_add;
    logic             last_term;

    always_comb begin
        sum       = {1'b0, acc_reg} + {{(ACC_W + 1 - 16){1'b0}}, prod_in};
        carry     = sum[ACC_W];
`ifdef MAC_ACCUMULATOR_SATURATE_EN
        // Once clamped, the sum stays pinned at all-ones for the rest of the run.
        acc_add   = (carry || ovf_reg) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
        acc_add   = sum[ACC_W-1:0];
`endif
        last_term = (cnt_reg + CNT_W'(1)) == len_reg;
    end

    // State register
    always_ff @(posedge cclk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = (len == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (prod_valid && last_term) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Accumulator datapath
    always_ff @(posedge cclk) begin
        if (!rst_n) begin
            acc_reg <= '0;
            cnt_reg <= '0;
            len_reg <= '0;
            ovf_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        acc_reg <= '0;
                        cnt_reg <= '0;
                        len_reg <= len;
                        ovf_reg <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (prod_valid) begin
                        acc_reg <= acc_add;
                        cnt_reg <= cnt_reg + CNT_W'(1);
                        if (carry) begin
                            ovf_reg <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        acc_out   = acc_reg;
        out_valid = (state_reg == DONE);
        busy      = (state_reg != IDLE);
        overflow  = ovf_reg;
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed self-checking bench for mac_accumulator (ACC_W=16 so overflow is reachable).
module tb_mac_accumulator;

    localparam int ACC_W = 16;
    localparam int CNT_W = 8;
`ifdef MAC_ACCUMULATOR_SATURATE_EN
    localparam logic [15:0] OVF_SUM = 16'd65535;
`else
    localparam logic [15:0] OVF_SUM = 16'd489;
`endif

    logic             cclk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] len;
    logic [15:0]      prod_in;
    logic             prod_valid;
    logic [ACC_W-1:0] acc_out;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             overflow;

    int checks = 0;
    int errors = 0;

    always #5 cclk = ~cclk;

    mac_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .cclk       (cclk),
        .rst_n      (rst_n),
        .start      (start),
        .len        (len),
        .prod_in    (prod_in),
        .prod_valid (prod_valid),
        .acc_out    (acc_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .overflow   (overflow)
    );

    typedef struct {
        logic        rst_n;
        logic        start;
        logic [7:0]  len;
        logic        pv;
        logic [15:0] prod;
        logic        rdy;
        logic [15:0] e_acc;
        logic        e_v;
        logic        e_b;
        logic        e_o;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mkv(logic r, logic s, logic [7:0] l, logic pv, logic [15:0] p,
                                 logic rdy, logic [15:0] ea, logic ev, logic eb, logic eo);
        vec_t v;
        v.rst_n = r; v.start = s; v.len = l; v.pv = pv; v.prod = p; v.rdy = rdy;
        v.e_acc = ea; v.e_v = ev; v.e_b = eb; v.e_o = eo;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic [7:0] l,
                         input logic pv, input logic [15:0] p, input logic rdy);
        rst_n = r; start = s; len = l; prod_valid = pv; prod_in = p; out_ready = rdy;
    endtask

    task automatic tick();
        @(posedge cclk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [15:0] ea, input logic ev,
                             input logic eb, input logic eo);
        check({tag, " acc_out"}, int'(acc_out), int'(ea));
        check({tag, " out_valid"}, int'(out_valid), int'(ev));
        check({tag, " busy"}, int'(busy), int'(eb));
        check({tag, " overflow"}, int'(overflow), int'(eo));
    endtask

    initial begin
        drive(1'b0, 1'b0, 8'd0, 1'b0, 16'd0, 1'b0);

        //         rst start len  pv  prod   rdy   acc      v  b  o
        vq.push_back(mkv(0, 0, 8'd0, 0, 16'd0,     0, 16'd0,     0, 0, 0)); // reset
        vq.push_back(mkv(1, 1, 8'd3, 0, 16'd0,     0, 16'd0,     0, 1, 0)); // basic run
        vq.push_back(mkv(1, 0, 8'd0, 1, 16'd15,    0, 16'd15,    0, 1, 0));
        vq.push_back(mkv(1, 0, 8'd0, 1, 16'd200,   0, 16'd215,   0, 1, 0));
        vq.push_back(mkv(1, 0, 8'd0, 1, 16'd65025, 0, 16'd65240, 1, 1, 0));
        vq.push_back(mkv(1, 0, 8'd0, 0, 16'd0,     0, 16'd65240, 1, 1, 0));
        vq.push_back(mkv(1, 0, 8'd0, 0, 16'd0,     1, 16'd65240, 0, 0, 0));
        vq.push_back(mkv(1, 0, 8'd0, 1, 16'd999,   0, 16'd65240, 0, 0, 0)); // pv in IDLE
        vq.push_back(mkv(1, 1, 8'd0, 0, 16'd0,     0, 16'd0,     1, 1, 0)); // zero length
        vq.push_back(mkv(1, 1, 8'd0, 1, 16'd500,   0, 16'd0,     1, 1, 0));
        vq.push_back(mkv(1, 1, 8'd0, 0, 16'd0,     1, 16'd0,     0, 0, 0)); // start+ready
        vq.push_back(mkv(1, 0, 8'd0, 0, 16'd0,     0, 16'd0,     0, 0, 0));
        vq.push_back(mkv(1, 1, 8'd2, 0, 16'd0,     0, 16'd0,     0, 1, 0)); // overflow
        vq.push_back(mkv(1, 1, 8'd5, 1, 16'd65025, 0, 16'd65025, 0, 1, 0)); // start in ACCUM
        vq.push_back(mkv(1, 0, 8'd0, 1, 16'd1000,  0, OVF_SUM,   1, 1, 1));
        vq.push_back(mkv(1, 0, 8'd0, 0, 16'd0,     1, OVF_SUM,   0, 0, 1)); // sticky
        vq.push_back(mkv(1, 1, 8'd1, 0, 16'd0,     0, 16'd0,     0, 1, 0)); // start clears
        vq.push_back(mkv(1, 0, 8'd0, 1, 16'd7,     0, 16'd7,     1, 1, 0));
        vq.push_back(mkv(1, 0, 8'd0, 0, 16'd0,     1, 16'd7,     0, 0, 0));
        vq.push_back(mkv(1, 1, 8'd4, 0, 16'd0,     0, 16'd0,     0, 1, 0)); // mid-run reset
        vq.push_back(mkv(1, 0, 8'd0, 1, 16'd10,    0, 16'd10,    0, 1, 0));
        vq.push_back(mkv(1, 0, 8'd0, 1, 16'd20,    0, 16'd30,    0, 1, 0));
        vq.push_back(mkv(0, 0, 8'd0, 1, 16'd40,    0, 16'd0,     0, 0, 0));
        vq.push_back(mkv(1, 1, 8'd1, 0, 16'd0,     0, 16'd0,     0, 1, 0));
        vq.push_back(mkv(1, 0, 8'd0, 1, 16'd7,     0, 16'd7,     1, 1, 0));
        vq.push_back(mkv(1, 0, 8'd0, 0, 16'd0,     1, 16'd7,     0, 0, 0));

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst_n, vq[i].start, vq[i].len, vq[i].pv, vq[i].prod, vq[i].rdy);
            tick();
            check_all($sformatf("vec%0d", i), vq[i].e_acc, vq[i].e_v, vq[i].e_b, vq[i].e_o);
            $display("vec %0d: acc_out=%0d out_valid=%0d busy=%0d overflow=%0d",
                     i, acc_out, out_valid, busy, overflow);
        end

        // Gaps between products, then backpressure on the result.
        drive(1'b1, 1'b1, 8'd2, 1'b0, 16'd0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 8'd0, 1'b1, 16'd100, 1'b0);
        tick();
        check_all("gap first", 16'd100, 1'b0, 1'b1, 1'b0);
        for (int g = 0; g < 3; g++) begin
            drive(1'b1, 1'b0, 8'd0, 1'b0, 16'd0, 1'b0);
            tick();
            check_all($sformatf("gap hold%0d", g), 16'd100, 1'b0, 1'b1, 1'b0);
        end
        drive(1'b1, 1'b0, 8'd0, 1'b1, 16'd50, 1'b0);
        tick();
        check_all("gap last", 16'd150, 1'b1, 1'b1, 1'b0);
        for (int b = 0; b < 5; b++) begin
            drive(1'b1, 1'b0, 8'd0, 1'b0, 16'd0, 1'b0);
            tick();
            check_all($sformatf("bp hold%0d", b), 16'd150, 1'b1, 1'b1, 1'b0);
        end
        drive(1'b1, 1'b0, 8'd0, 1'b0, 16'd0, 1'b1);
        begin
            int waited = 0;
            tick();
            while (out_valid && waited < 4) begin
                tick();
                waited++;
            end
            check("bp release latency", waited, 0);
        end
        check("bp release busy", int'(busy), 0);
        check("bp release valid", int'(out_valid), 0);
        $display("backpressure: acc_out=%0d out_valid=%0d busy=%0d", acc_out, out_valid, busy);

        drive(1'b1, 1'b0, 8'd0, 1'b0, 16'd0, 1'b0);
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
